serv_cnt_seq: RTL and testbench

SERV_CNT_SEQ -- requirements
Module: serv_cnt_seq

---
 rtl/serv_pkg.sv | 23 ++
 rtl/serv_cnt_seq.sv | 116 +++++++++++
 tb/tb_serv_cnt_seq.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serv_pkg.sv
// Shared definitions for the SERV-style bit-serial sequencing logic.
//   state_e    : sequencer states (IDLE / INIT / RUN)
//   beats_of() : number of beats in one 32-bit pass for a datapath width w
//   cnt_width(): width of the beat counter for a datapath width w (at least 1)
package serv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic int beats_of(input int w);
    return 32 / w;
  endfunction

  function automatic int cnt_width(input int w);
    int b;
    b = 32 / w;
    return (b > 2) ? $clog2(b) : 1;
  endfunction

endpackage

// File: rtl/serv_cnt_seq.sv
// Beat counter and operation sequencer for a W-bit serial datapath.
// A 32-bit operation is processed as BEATS = 32/W beats. Two-stage
// operations (compare/branch/slt) run an INIT pass before the RUN pass.
//
// Ports:
//   clk         : clock, rising edge
//   i_rst_n     : asynchronous active-low reset
//   i_start     : begin an operation (sampled only in IDLE)
//   i_two_stage : operation needs an INIT pass first (sampled with i_start)
//   i_rd_wen    : decoded instruction writes rd
//   i_stall     : hold the current beat
//   i_abort     : synchronous cancel (trap / flush)
//   o_busy      : state is not IDLE
//   o_init      : state is INIT
//   o_en        : beat-advance enable to the ALU
//   o_cnt0      : current beat is 0
//   o_cnt_last  : current beat is BEATS-1
//   o_cnt       : current beat index
//   o_rf_wen    : write the current rd beat to the register file
//   o_done      : one-cycle completion pulse (registered)
module serv_cnt_seq
  import serv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_two_stage,
  input  logic                       i_rd_wen,
  input  logic                       i_stall,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_init,
  output logic                       o_en,
  output logic                       o_cnt0,
  output logic                       o_cnt_last,
  output logic [cnt_width(W)-1:0]    o_cnt,
  output logic                       o_rf_wen,
  output logic                       o_done
);

  localparam int BEATS = beats_of(W);
  localparam int CW    = cnt_width(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(BEATS - 1);

  state_e          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            done_reg, done_next;
  logic            busy;
  logic            en;
  logic            at_last;

  assign busy    = (state_reg != IDLE);
  // Abort masks the enable so an aborted beat never reaches the ALU or RF.
  assign en      = busy & ~i_stall & ~i_abort;
  assign at_last = busy & (cnt_reg == CNT_LAST);

  assign o_busy     = busy;
  assign o_init     = (state_reg == INIT);
  assign o_en       = en;
  assign o_cnt0     = busy & (cnt_reg == '0);
  assign o_cnt_last = at_last;
  assign o_cnt      = cnt_reg;
  assign o_rf_wen   = en & (state_reg == RUN) & i_rd_wen;
  assign o_done     = done_reg;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        // A start coinciding with abort is dropped.
        if (i_start && !i_abort) begin
          state_next = i_two_stage ? INIT : RUN;
          cnt_next   = '0;
        end
      end
      INIT, RUN: begin
        // Abort outranks both stall and completion.
        if (i_abort) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (en) begin
          cnt_next = at_last ? '0 : cnt_reg + CW'(1);
          if (at_last) begin
            if (state_reg == INIT) begin
              state_next = RUN;
            end else begin
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_serv_cnt_seq.sv
module tb_serv_cnt_seq;

  logic       clk;
  logic       i_rst_n;
  logic       i_start;
  logic       i_two_stage;
  logic       i_rd_wen;
  logic       i_stall;
  logic       i_abort;
  logic       o_busy;
  logic       o_init;
  logic       o_en;
  logic       o_cnt0;
  logic       o_cnt_last;
  logic [2:0] o_cnt;
  logic       o_rf_wen;
  logic       o_done;

  int errors = 0;
  int checks = 0;

  // {busy, init, en, cnt0, cnt_last, rf_wen, done, cnt[2:0]}
  logic [9:0] obs;
  logic [9:0] exp_v;
  assign obs = {o_busy, o_init, o_en, o_cnt0, o_cnt_last, o_rf_wen, o_done, o_cnt};

  serv_cnt_seq #(.W(4)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_two_stage(i_two_stage),
    .i_rd_wen   (i_rd_wen),
    .i_stall    (i_stall),
    .i_abort    (i_abort),
    .o_busy     (o_busy),
    .o_init     (o_init),
    .o_en       (o_en),
    .o_cnt0     (o_cnt0),
    .o_cnt_last (o_cnt_last),
    .o_cnt      (o_cnt),
    .o_rf_wen   (o_rf_wen),
    .o_done     (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ev(input bit busy, input bit init, input bit en,
                                    input bit c0, input bit cl, input bit rf,
                                    input bit dn, input int cnt);
    logic [2:0] c;
    c = 3'(cnt);
    return {busy, init, en, c0, cl, rf, dn, c};
  endfunction

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b1; i_two_stage = 1'b0; i_rd_wen = 1'b1;
    i_stall = 1'b0; i_abort = 1'b0;
    #3;
    exp_v = ev(0,0,0,0,0,0,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_held: got %b expected %b", obs, exp_v); end
    cyc(); cyc();
    $display("reset: outputs during reset %b", obs);
    i_rst_n = 1'b1; i_start = 1'b0;
    #1;
    exp_v = ev(0,0,0,0,0,0,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_release: got %b expected %b", obs, exp_v); end
    cyc(); #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL reset_idle: got %b expected %b", obs, exp_v); end
  endtask

  task automatic test_single();
    cyc();
    i_start = 1'b1; i_two_stage = 1'b0; i_rd_wen = 1'b1;
    #1;
    exp_v = ev(0,0,0,0,0,0,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL single_idle: got %b expected %b", obs, exp_v); end
    cyc();
    i_start = 1'b0;
    for (int b = 0; b < 8; b++) begin
      #1;
      exp_v = ev(1,0,1,b==0,b==7,1,0,b);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL single_beat%0d: got %b expected %b", b, obs, exp_v); end
      cyc();
    end
    #1;
    exp_v = ev(0,0,0,0,0,0,1,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL single_done: got %b expected %b", obs, exp_v); end
    cyc(); #1;
    exp_v = ev(0,0,0,0,0,0,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL single_after: got %b expected %b", obs, exp_v); end
    $display("single: 8 beats then done");
  endtask

  task automatic test_two_stage();
    cyc();
    i_start = 1'b1; i_two_stage = 1'b1; i_rd_wen = 1'b1;
    cyc();
    i_start = 1'b0; i_two_stage = 1'b0;
    for (int b = 0; b < 8; b++) begin
      #1;
      exp_v = ev(1,1,1,b==0,b==7,0,0,b);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL two_init%0d: got %b expected %b", b, obs, exp_v); end
      cyc();
    end
    for (int b = 0; b < 8; b++) begin
      #1;
      exp_v = ev(1,0,1,b==0,b==7,1,0,b);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL two_run%0d: got %b expected %b", b, obs, exp_v); end
      cyc();
    end
    #1;
    exp_v = ev(0,0,0,0,0,0,1,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL two_done: got %b expected %b", obs, exp_v); end
    $display("two_stage: 8 init + 8 run beats then done");
  endtask

  task automatic test_stall();
    cyc();
    i_start = 1'b1; i_two_stage = 1'b0; i_rd_wen = 1'b0;
    cyc();
    i_start = 1'b0;
    for (int b = 0; b < 7; b++) begin
      #1;
      exp_v = ev(1,0,1,b==0,0,0,0,b);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL stall_beat%0d: got %b expected %b", b, obs, exp_v); end
      cyc();
    end
    i_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      exp_v = ev(1,0,0,0,1,0,0,7);
      checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL stall_hold%0d: got %b expected %b", s, obs, exp_v); end
      cyc();
    end
    i_stall = 1'b0;
    #1;
    exp_v = ev(1,0,1,0,1,0,0,7);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_release: got %b expected %b", obs, exp_v); end
    cyc(); #1;
    exp_v = ev(0,0,0,0,0,0,1,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL stall_done: got %b expected %b", obs, exp_v); end
    $display("stall: beat 7 held 3 cycles, done delayed");
  endtask

  task automatic test_abort();
    cyc();
    i_start = 1'b1; i_two_stage = 1'b1; i_rd_wen = 1'b1;
    cyc();
    i_start = 1'b0;
    for (int b = 0; b < 4; b++) cyc();
    i_abort = 1'b1; i_start = 1'b1; i_stall = 1'b1;
    #1;
    exp_v = ev(1,1,0,0,0,0,0,4);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL abort_at4: got %b expected %b", obs, exp_v); end
    cyc();
    i_abort = 1'b0; i_start = 1'b0; i_stall = 1'b0;
    #1;
    exp_v = ev(0,0,0,0,0,0,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL abort_idle: got %b expected %b", obs, exp_v); end
    cyc(); #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL abort_no_done: got %b expected %b", obs, exp_v); end
    // abort in IDLE blocks a simultaneous start
    i_abort = 1'b1; i_start = 1'b1; i_two_stage = 1'b0;
    cyc();
    i_abort = 1'b0; i_start = 1'b0;
    #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL abort_blocks_start: got %b expected %b", obs, exp_v); end
    i_start = 1'b1;
    cyc();
    i_start = 1'b0;
    #1;
    exp_v = ev(1,0,1,1,0,1,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL abort_restart: got %b expected %b", obs, exp_v); end
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    #1;
    exp_v = ev(0,0,0,0,0,0,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL abort_run: got %b expected %b", obs, exp_v); end
    $display("abort: INIT beat 4 cancelled, restart accepted");
  endtask

  task automatic test_back_to_back();
    cyc();
    i_start = 1'b1; i_two_stage = 1'b0; i_rd_wen = 1'b1;
    cyc();
    for (int b = 0; b < 8; b++) cyc();
    #1;
    exp_v = ev(0,0,0,0,0,0,1,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_gap: got %b expected %b", obs, exp_v); end
    cyc();
    #1;
    exp_v = ev(1,0,1,1,0,1,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_second: got %b expected %b", obs, exp_v); end
    i_start = 1'b0;
    for (int b = 0; b < 8; b++) cyc();
    #1;
    exp_v = ev(0,0,0,0,0,0,1,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL b2b_done2: got %b expected %b", obs, exp_v); end
    $display("back_to_back: one-cycle gap between operations");
  endtask

  task automatic test_async_reset();
    cyc();
    i_start = 1'b1; i_two_stage = 1'b0; i_rd_wen = 1'b1;
    cyc();
    i_start = 1'b0;
    for (int b = 0; b < 5; b++) cyc();
    #1;
    exp_v = ev(1,0,1,0,0,1,0,5);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_beat5: got %b expected %b", obs, exp_v); end
    #1;
    i_rst_n = 1'b0;
    #1;
    exp_v = ev(0,0,0,0,0,0,0,0);
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_immediate: got %b expected %b", obs, exp_v); end
    @(negedge clk);
    i_rst_n = 1'b1;
    cyc(); #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_idle: got %b expected %b", obs, exp_v); end
    cyc(); #1;
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL areset_no_done: got %b expected %b", obs, exp_v); end
    $display("async_reset: RUN beat 5 discarded");
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_stage();
    test_stall();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
